// File: rtl/vc_flow_arbiter.sv
// vc_flow_arbiter: round-robin arbiter draining four virtual-channel FWFT
// source FIFOs into one downstream port. Per-VC pause flags come from
// pause/continue strobes. Any overflow error locks the block into HALT
// until reset.
module vc_flow_arbiter #(
    parameter int DATA_W = 6
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic [3:0]            pause_stb,
    input  logic [3:0]            continue_stb,
    input  logic [3:0]            error_full,
    input  logic [3:0]            src_empty,
    input  logic [4*DATA_W-1:0]   src_data,
    input  logic                  dest_ready,
    output logic [3:0]            src_pop,
    output logic [DATA_W-1:0]     data_out,
    output logic                  valid_out,
    output logic [1:0]            vc_out,
    output logic [3:0]            paused,
    output logic                  halted,
    output logic [7:0]            word_count
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t     state;
    logic [1:0] ptr;
    logic [3:0] eligible;
    logic       grant_vld;
    logic [1:0] grant_idx;
    logic [1:0] cand;

    // A VC may pop only when it has data and is not paused. The arbiter must
    // also be running, downstream must be ready, and reset must be released.
    // The registered pause flag is used, so a pause strobe blocks from the
    // next cycle on.
    always_comb begin
        eligible = 4'b0000;
        if (reset && state == RUN && dest_ready)
            eligible = ~src_empty & ~paused;
    end

    // Round-robin search starting at ptr; the first eligible VC wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 2'd0;
        cand      = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand = ptr + 2'(k);
            if (!grant_vld && eligible[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign src_pop = grant_vld ? (4'b0001 << grant_idx) : 4'b0000;

    // Control FSM: RUN/HALT, pause flags, rotation pointer and word counter.
    // Pause flags and the counter are frozen in HALT. HALT makes no grants,
    // so the pointer and counter cannot move there.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            state      <= RUN;
            halted     <= 1'b0;
            paused     <= 4'b0000;
            ptr        <= 2'd0;
            word_count <= 8'd0;
        end else begin
            if (state == RUN) begin
                if (|error_full) begin
                    state  <= HALT;
                    halted <= 1'b1;
                end
                // When pause and continue arrive together, pause wins.
                paused <= pause_stb | (paused & ~continue_stb);
            end
            if (grant_vld) begin
                ptr        <= grant_idx + 2'd1;
                word_count <= word_count + 8'd1;
            end
        end
    end

    // Output register: forward the granted head word one cycle after the
    // pop. When nothing is granted, data_out and vc_out hold their values.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            vc_out    <= 2'd0;
        end else begin
            valid_out <= grant_vld;
            if (grant_vld) begin
                data_out <= src_data[grant_idx*DATA_W +: DATA_W];
                vc_out   <= grant_idx;
            end
        end
    end

endmodule

// File: tb/tb_vc_flow_arbiter.sv
// Testbench for vc_flow_arbiter: directed scenarios plus randomized traffic,
// checked against a queue-based behavioural model and a scoreboard monitor.
module tb_vc_flow_arbiter;

    localparam int DW = 6;

    logic            CLK;
    logic            reset;
    logic [3:0]      pause_stb, continue_stb, error_full, src_empty;
    logic [4*DW-1:0] src_data;
    logic            dest_ready;
    logic [3:0]      src_pop;
    logic [DW-1:0]   data_out;
    logic            valid_out;
    logic [1:0]      vc_out;
    logic [3:0]      paused;
    logic            halted;
    logic [7:0]      word_count;

    vc_flow_arbiter #(.DATA_W(DW)) dut (
        .CLK(CLK), .reset(reset), .pause_stb(pause_stb),
        .continue_stb(continue_stb), .error_full(error_full),
        .src_empty(src_empty), .src_data(src_data), .dest_ready(dest_ready),
        .src_pop(src_pop), .data_out(data_out), .valid_out(valid_out),
        .vc_out(vc_out), .paused(paused), .halted(halted),
        .word_count(word_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int vc;
        int data;
    } exp_t;
    exp_t exp_q[$];

    // Behavioural model state
    int       m_ptr;
    bit [3:0] m_paused;
    bit       m_halted;
    int       m_count;
    int       m_data;
    int       m_vc;
    bit       m_init = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check the combinational pop and the
    // registered state against the model, then advance the model.
    task automatic cycle(input bit rn, input logic [3:0] ps, input logic [3:0] cs,
                         input logic [3:0] ef, input logic [3:0] em, input bit rdy,
                         input logic [4*DW-1:0] d, output logic [3:0] pop_seen);
        logic [3:0] exp_pop;
        int g;
        @(posedge CLK);
        #1;
        reset = rn; pause_stb = ps; continue_stb = cs; error_full = ef;
        src_empty = em; dest_ready = rdy; src_data = d;
        @(negedge CLK);
        if (m_init) begin
            check("paused", paused, m_paused);
            check("halted", halted, m_halted);
            check("word_count", word_count, m_count);
            check("data_out_reg", data_out, m_data);
            check("vc_out_reg", vc_out, m_vc);
        end
        g = -1;
        if (rn && !m_halted && rdy) begin
            for (int k = 0; k < 4; k++) begin
                int v;
                v = (m_ptr + k) % 4;
                if (g < 0 && !em[v] && !m_paused[v]) g = v;
            end
        end
        exp_pop = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        check("src_pop", src_pop, exp_pop);
        pop_seen = src_pop;
        if (!rn) begin
            m_ptr = 0; m_paused = 4'b0; m_halted = 1'b0; m_count = 0;
            m_data = 0; m_vc = 0; m_init = 1'b1;
        end else begin
            if (g >= 0) begin
                exp_t e;
                e.vc   = g;
                e.data = int'(d[g*DW +: DW]);
                exp_q.push_back(e);
                m_ptr   = (g + 1) % 4;
                m_count = (m_count + 1) % 256;
                m_data  = e.data;
                m_vc    = g;
            end
            if (!m_halted) begin
                for (int i = 0; i < 4; i++) begin
                    if (ps[i]) m_paused[i] = 1'b1;
                    else if (cs[i]) m_paused[i] = 1'b0;
                end
                if (ef != 4'b0) m_halted = 1'b1;
            end
        end
    endtask

    // Scoreboard monitor: every valid output word must match the oldest
    // outstanding grant.
    initial begin
        forever begin
            @(posedge CLK);
            #2;
            if (valid_out === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("mon_vc_out", vc_out, e.vc);
                    check("mon_data_out", data_out, e.data);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [3:0]      pop;
        logic [4*DW-1:0] seq_data;
        reset = 1'b0; pause_stb = '0; continue_stb = '0; error_full = '0;
        src_empty = 4'hF; dest_ready = 1'b0; src_data = '0;
        seq_data = {6'd4, 6'd3, 6'd2, 6'd1};

        // Reset, then check reset values
        cycle(0, 0, 0, 0, 4'hF, 0, 0, pop);
        cycle(1, 0, 0, 0, 4'hF, 0, 0, pop);
        check("rst_valid_out", valid_out, 0);
        check("rst_word_count", word_count, 0);

        // Plain rotation over all VCs
        for (int i = 0; i < 5; i++) begin
            cycle(1, 0, 0, 0, 4'h0, 1, seq_data, pop);
            check("rr_seq", pop, 4'b0001 << (i % 4));
        end

        // Pause VC1 just as it is next in line, then continue it
        cycle(0, 0, 0, 0, 4'h0, 1, seq_data, pop);
        cycle(1, 0, 0, 0, 4'h0, 1, seq_data, pop);          // VC0
        cycle(1, 4'b0010, 0, 0, 4'h0, 1, seq_data, pop);    // VC1 still popped
        check("pause_same_cycle_pop", pop, 4'b0010);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 4'h0, 1, seq_data, pop);
        check("paused_vc1", paused, 4'b0010);
        cycle(1, 0, 4'b0010, 0, 4'h0, 1, seq_data, pop);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 4'h0, 1, seq_data, pop);

        // Pause and continue together: pause wins
        cycle(1, 4'b0100, 4'b0100, 0, 4'h0, 1, seq_data, pop);
        cycle(1, 0, 0, 0, 4'h0, 1, seq_data, pop);
        check("pause_wins", paused[2], 1);

        // Error while VC0 is granted: that word completes, then HALT
        cycle(0, 0, 0, 0, 4'h0, 1, seq_data, pop);
        cycle(1, 0, 0, 4'b1000, 4'h0, 1, seq_data, pop);
        check("err_cycle_pop", pop, 4'b0001);
        cycle(1, 0, 0, 0, 4'h0, 1, seq_data, pop);
        check("halt_flag", halted, 1);
        check("halt_last_valid", valid_out, 1);
        check("halt_last_vc", vc_out, 0);
        check("halt_no_pop", pop, 0);
        for (int i = 0; i < 3; i++) cycle(1, 4'hF, 0, 0, 4'h0, 1, seq_data, pop);
        check("halt_valid_low", valid_out, 0);
        cycle(0, 0, 0, 0, 4'h0, 1, seq_data, pop);
        cycle(1, 0, 0, 0, 4'hF, 1, seq_data, pop);
        check("post_rst_halted", halted, 0);
        check("post_rst_data_out", data_out, 0);

        // Counter wrap and dest_ready stall
        for (int i = 0; i < 260; i++) cycle(1, 0, 0, 0, 4'h0, 1, seq_data, pop);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0, 0, 4'h0, 0, seq_data, pop);
            check("stall_no_pop", pop, 0);
        end
        check("word_count_wrap", word_count, 4);
        cycle(1, 0, 0, 0, 4'h0, 1, seq_data, pop);
        check("resume_same_vc", pop, 4'b0001);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] ps, cs, ef;
            ps = '0; cs = '0; ef = '0;
            for (int b = 0; b < 4; b++) begin
                ps[b] = ($urandom_range(0, 9) == 0);
                cs[b] = ($urandom_range(0, 4) == 0);
            end
            if ($urandom_range(0, 299) == 0) ef = 4'b0001 << $urandom_range(0, 3);
            cycle(($urandom_range(0, 199) != 0), ps, cs, ef, 4'($urandom),
                  ($urandom_range(0, 4) != 0), (4*DW)'($urandom), pop);
        end

        // Drain the pipeline
        cycle(1, 0, 0, 0, 4'hF, 0, 0, pop);
        cycle(1, 0, 0, 0, 4'hF, 0, 0, pop);
        check("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
